// File: rtl/ps2_keyevent_rx.sv
// PS/2 keyboard receiver: synchronises the raw bus, deframes 11-bit frames and queues key events.
// Optional prefix decoder (E0/F0 -> ext/brk flags) is enabled by defining PS2_KEYEVENT_DECODE_EN.
module ps2_keyevent_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [9:0] ev_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       overflow,
  output logic [7:0] err_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   pulse;
  logic                   bit_in;

  logic [3:0]    bit_cnt;
  logic [TW-1:0] to_cnt;
  logic [9:0]    shreg;
  logic [10:0]   frame_w;
  logic          frame_ok;
  logic          last;
  logic          accept;
  logic          bad;
  logic          to_hit;
  logic [7:0]    rx_byte;

  logic          push;
  logic [9:0]    push_data;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          pop;
  logic          wr_en;

  // Bring the asynchronous bus into the clk domain; idle-high on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign pulse  = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES-2];
  assign bit_in = data_sync[SYNC_STAGES-1];

  assign frame_w  = {bit_in, shreg};
  assign frame_ok = ~frame_w[0] & frame_w[10] & (^frame_w[9:1]);
  assign last     = pulse & (bit_cnt == 4'd10);
  assign accept   = last & frame_ok;
  assign bad      = last & ~frame_ok;
  assign rx_byte  = frame_w[8:1];
  assign to_hit   = (bit_cnt != 4'd0) & ~pulse
                  & (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Shift in frame bits LSB-first; first bit ends up in shreg[0]
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
    end else if (pulse) begin
      shreg <= frame_w[10:1];
    end
  end

  // Bit counter and stalled-frame timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      to_cnt  <= '0;
    end else if (pulse) begin
      to_cnt  <= '0;
      bit_cnt <= last ? 4'd0 : bit_cnt + 4'd1;
    end else if (bit_cnt != 4'd0) begin
      if (to_hit) begin
        bit_cnt <= '0;
        to_cnt  <= '0;
      end else begin
        to_cnt <= to_cnt + TW'(1);
      end
    end else begin
      to_cnt <= '0;
    end
  end

  // Saturating count of malformed or abandoned frames
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if ((bad | to_hit) && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

`ifdef PS2_KEYEVENT_DECODE_EN
  logic ext_q;
  logic brk_q;
  logic is_e0;
  logic is_f0;

  assign is_e0     = (rx_byte == 8'hE0);
  assign is_f0     = (rx_byte == 8'hF0);
  assign push      = accept & ~is_e0 & ~is_f0;
  assign push_data = {ext_q, brk_q, rx_byte};

  // Prefix flags; cleared by any non-prefix byte, even if its push is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (accept) begin
      if (is_e0) begin
        ext_q <= 1'b1;
      end else if (is_f0) begin
        brk_q <= 1'b1;
      end else begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
    end
  end
`else
  assign push      = accept;
  assign push_data = {2'b00, rx_byte};
`endif

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW])
                  & (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = ~empty & ev_ready;
  assign wr_en    = push & (~full | pop);
  assign ev_valid = ~empty;
  assign ev_data  = mem[rd_ptr[AW-1:0]];

  // Event storage; contents need no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // FIFO pointers with an extra wrap bit for full/empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Sticky flag for an event lost to a full FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push & full & ~pop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_keyevent_rx.sv
// Scoreboard bench for ps2_keyevent_rx: directed PS/2 frames, queued expectations,
// monitor compares each accepted event; prefix expectations follow PS2_KEYEVENT_DECODE_EN.
module tb_ps2_keyevent_rx;

  localparam int D  = 4;
  localparam int S  = 3;
  localparam int TO = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [9:0] ev_data;
  logic       ev_valid;
  logic       ev_ready = 1'b0;
  logic       overflow;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  logic [9:0] exp_q[$];

  ps2_keyevent_rx #(
    .FIFO_DEPTH(D),
    .SYNC_STAGES(S),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .ev_data(ev_data),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .overflow(overflow),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: consume expectations on every handshake
  initial begin
    forever begin
      @(negedge clk);
      if (ev_valid) vcnt++;
      if (ev_valid && ev_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got %0h expected none", ev_data);
        end else begin
          chk("event", 32'(ev_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  function automatic logic [10:0] mk(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic send(input logic [10:0] f, input int nbits, input bit pop_last);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (10) @(posedge clk);
      #1 ps2_clk = 1'b0;
      if (pop_last && i == nbits - 1) begin
        repeat (S - 1) @(posedge clk);
        #1 ev_ready = 1'b1;
        @(posedge clk);
        #1 ev_ready = 1'b0;
        repeat (10 - S) @(posedge clk);
      end else begin
        repeat (10) @(posedge clk);
      end
      #1 ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(ev_valid), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending expected 0", nm, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
    chk({nm, "_valid_low"}, 32'(ev_valid), 0);
  endtask

  initial begin
    do_reset();

    // single make code, consumer always ready
    #1 ev_ready = 1'b1;
    vcnt = 0;
    exp_q.push_back(10'h01C);
    send(mk(8'h1C), 11, 0);
    wait_drain("t1c");
    chk("t1c_valid_cycles", 32'(vcnt), 1);
    chk("t1c_err_cnt", 32'(err_cnt), 0);

    // extended break sequence
`ifdef PS2_KEYEVENT_DECODE_EN
    exp_q.push_back(10'h375);
`else
    exp_q.push_back(10'h0E0);
    exp_q.push_back(10'h0F0);
    exp_q.push_back(10'h075);
`endif
    send(mk(8'hE0), 11, 0);
    send(mk(8'hF0), 11, 0);
    send(mk(8'h75), 11, 0);
    wait_drain("prefix");

    // bad parity then bad stop
    send(mk(8'h1C) ^ 11'h200, 11, 0);
    send(mk(8'h1C) & 11'h3FF, 11, 0);
    repeat (5) @(negedge clk);
    chk("bad_err_cnt", 32'(err_cnt), 2);
    chk("bad_no_event", 32'(ev_valid), 0);

    // stalled frame then a good one
    do_reset();
    #1 ev_ready = 1'b1;
    send(mk(8'h1C), 4, 0);
    repeat (TO + 1) @(posedge clk);
    exp_q.push_back(10'h01C);
    send(mk(8'h1C), 11, 0);
    wait_drain("timeout");
    chk("timeout_err_cnt", 32'(err_cnt), 1);

    // reset mid-frame is not an error
    send(mk(8'h2C), 5, 0);
    do_reset();
    #1 ev_ready = 1'b1;
    exp_q.push_back(10'h01C);
    send(mk(8'h1C), 11, 0);
    wait_drain("midrst");
    chk("midrst_err_cnt", 32'(err_cnt), 0);

    // overflow with a stalled consumer
    #1 ev_ready = 1'b0;
    exp_q.push_back(10'h015);
    exp_q.push_back(10'h01D);
    exp_q.push_back(10'h024);
    exp_q.push_back(10'h02D);
    send(mk(8'h15), 11, 0);
    send(mk(8'h1D), 11, 0);
    send(mk(8'h24), 11, 0);
    send(mk(8'h2D), 11, 0);
    @(negedge clk);
    chk("full_no_ovf", 32'(overflow), 0);
    send(mk(8'h2C), 11, 0);
    @(negedge clk);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_valid", 32'(ev_valid), 1);
    @(posedge clk);
    #1 ev_ready = 1'b1;
    wait_drain("ovf");
    chk("ovf_sticky", 32'(overflow), 1);

    // push while full coincident with a pop
    do_reset();
    #1 ev_ready = 1'b0;
    exp_q.push_back(10'h015);
    exp_q.push_back(10'h01D);
    exp_q.push_back(10'h024);
    exp_q.push_back(10'h02D);
    exp_q.push_back(10'h02C);
    send(mk(8'h15), 11, 0);
    send(mk(8'h1D), 11, 0);
    send(mk(8'h24), 11, 0);
    send(mk(8'h2D), 11, 0);
    send(mk(8'h2C), 11, 1);
    @(negedge clk);
    chk("pushpop_ovf", 32'(overflow), 0);
    chk("pushpop_left", 32'(exp_q.size()), 4);
    @(posedge clk);
    #1 ev_ready = 1'b1;
    wait_drain("pushpop");
    chk("pushpop_ovf_end", 32'(overflow), 0);
    chk("final_err_cnt", 32'(err_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_keyevent_rx.md
PS2_KEYEVENT_RX -- requirements
Module: ps2_keyevent_rx

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 8: event FIFO entries; power of two, 2..256.
REQ-002 SHALL provide parameter SYNC_STAGES, default 3: ps2_clk/ps2_data synchroniser flops; minimum 2.
REQ-003 SHALL provide parameter TIMEOUT_CYCLES, default 50000: clk cycles without a ps2_clk falling edge before a partial frame is abandoned.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port ps2_clk, input, 1: raw keyboard clock, asynchronous.
REQ-007 SHALL have port ps2_data, input, 1: raw keyboard data, asynchronous.
REQ-008 SHALL have port ev_data, output, 10: FIFO head {ext, brk, code[7:0]}.
REQ-009 SHALL have port ev_valid, output, 1: FIFO non-empty; ev_data is meaningful.
REQ-010 SHALL have port ev_ready, input, 1: consumer accepts the head when ev_valid & ev_ready.
REQ-011 SHALL have port overflow, output, 1: sticky; an event was dropped.
REQ-012 SHALL have port err_cnt, output, 8: saturating count of bad or timed-out frames.

Function
REQ-013 SHALL pass both inputs through SYNC_STAGES flops; a falling edge is synced ps2_clk going 1 to 0 between the last two stages, giving a one-cycle sample pulse.
REQ-014 SHALL sample synced ps2_data on each pulse into an 11-bit frame: start, 8 data LSB-first, parity, stop.
REQ-015 SHALL accept a frame only when start=0, stop=1, and the 8 data bits plus parity have odd parity; otherwise SHALL discard it and increment err_cnt.
REQ-016 SHALL return the bit counter to 0 after the 11th pulse, whether or not the frame is accepted.
REQ-017 SHALL clear the bit counter and increment err_cnt once if the counter is nonzero and TIMEOUT_CYCLES cycles pass with no pulse.
REQ-018 SHALL hold err_cnt at 255 once it reaches 255.
REQ-019 SHALL turn each accepted byte into a push request on the same cycle as the 11th pulse.
REQ-020 SHALL write a pushed event into the FIFO on that clock edge; ev_valid SHALL be 1 on the next cycle, giving one cycle of latency.
REQ-021 SHALL present the FIFO head combinationally on ev_data; a pop on ev_valid & ev_ready SHALL advance the read pointer.
REQ-022 SHALL track full/empty with pointers one bit wider than log2(FIFO_DEPTH), and pointers SHALL wrap naturally.
REQ-023 SHALL, on a push while full with no pop that cycle, drop the event, set overflow, and leave the FIFO contents unchanged.
REQ-024 SHALL, on a push while full with a pop in the same cycle, accept both and leave overflow unchanged.
REQ-025 SHALL, on a push while empty with ev_ready=1, not pop that cycle, since ev_valid was 0.
REQ-026 SHALL ignore ev_ready while ev_valid=0.

Reset
REQ-027 SHALL, with rst=1 at a clock edge, clear the bit counter, timeout counter, pointers, prefix flags, overflow (0) and err_cnt (0); ev_valid SHALL be 0 on the next cycle.
REQ-028 SHALL, on rst asserted mid-frame, abandon the frame without counting an error.
REQ-029 SHALL set the synchroniser flops to 1 (bus idle) on rst so no false edge follows reset.
REQ-030 SHALL leave FIFO storage contents uninitialised; ev_data is don't-care while ev_valid=0.

Configuration
REQ-031 SHALL, with macro PS2_KEYEVENT_DECODE_EN defined, run the prefix decoder: byte E0 sets the ext flag and F0 sets the brk flag, and neither is pushed.
REQ-032 SHALL, with PS2_KEYEVENT_DECODE_EN defined, push any other byte as {ext, brk, byte} and clear both flags.
REQ-033 SHALL, with PS2_KEYEVENT_DECODE_EN defined, clear the prefix flags if that push is dropped on overflow.
REQ-034 SHALL, without PS2_KEYEVENT_DECODE_EN, push every accepted byte as {0, 0, byte} and omit the prefix logic.

Verification
REQ-035 SHALL test: frame for byte 1C, ev_ready=1 -> one event 0x01C, ev_valid high for 1 cycle, err_cnt=0.
REQ-036 SHALL test with decode on: bytes E0,F0,75 -> single event 0x375; without decode -> 0x0E0, 0x0F0, 0x075.
REQ-037 SHALL test: frame with bad parity, then one with stop=0 -> no events, err_cnt=2.
REQ-038 SHALL test: 4 data bits then an idle of TIMEOUT_CYCLES+1 cycles, then a valid 1C frame -> err_cnt=1, event 0x01C.
REQ-039 SHALL test with FIFO_DEPTH=4 and ev_ready=0: 5 make codes 15,1D,24,2D,2C -> overflow=1, drain yields 15,1D,24,2D.
REQ-040 SHALL test with FIFO full: push coincident with a pop -> overflow stays 0 and the new event is retained.
